// File: rtl/fetch_queue.sv
// fetch_queue: decoupled RV32 instruction-fetch front end.
// Owns the fetch PC, issues sequential reads to imemory and buffers the
// returned {pc, insn} pairs in a DEPTH-entry FIFO drained by decode over a
// valid/ready handshake. A redirect flushes the queue and any in-flight read.
// Optional feature macro: FETCH_MISALIGN_CHECK_EN (misaligned-redirect fault).
module fetch_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0100_0000
) (
   input  logic                       clock,
   input  logic                       reset,
   output logic                       imem_req,
   output logic [31:0]                imem_addr,
   input  logic [31:0]                imem_data,
   input  logic                       redirect,
   input  logic [31:0]                redirect_pc,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [31:0]                out_pc,
   output logic [31:0]                out_insn,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       fault
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam logic [CW:0]   DEPTH_C = (CW+1)'(DEPTH);
   localparam logic [PW-1:0] PTR_ONE = PW'(1);

   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic          inflight_q, inflight_d;
   logic [31:0]   inflight_pc_q, inflight_pc_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          fault_q, fault_d;
   logic [31:0]   mem_pc_q   [DEPTH];
   logic [31:0]   mem_pc_d   [DEPTH];
   logic [31:0]   mem_insn_q [DEPTH];
   logic [31:0]   mem_insn_d [DEPTH];

   logic [CW:0]   occ_s;
   logic          issue_s;
   logic          push_s;
   logic          pop_s;
   logic [31:0]   target_s;
   logic          misalign_s;

   // Issue credit: occupancy before this cycle's pop plus the read in flight.
   always_comb begin
      occ_s   = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
      issue_s = reset & ~redirect & ~fault_q & (occ_s < DEPTH_C);
      push_s  = inflight_q & ~redirect;
      pop_s   = (count_q != {CW{1'b0}}) & out_ready;
   end

   // Redirect target handling; without the check the low PC bits are dropped.
   always_comb begin
`ifdef FETCH_MISALIGN_CHECK_EN
      target_s   = redirect_pc;
      misalign_s = |redirect_pc[1:0];
`else
      target_s   = redirect_pc & 32'hFFFF_FFFC;
      misalign_s = 1'b0;
`endif
   end

   // Next-state: redirect flushes everything, otherwise fill/drain/issue.
   always_comb begin
      fetch_pc_d    = fetch_pc_q;
      inflight_d    = inflight_q;
      inflight_pc_d = inflight_pc_q;
      rd_ptr_d      = rd_ptr_q;
      wr_ptr_d      = wr_ptr_q;
      count_d       = count_q;
      fault_d       = fault_q;
      mem_pc_d      = mem_pc_q;
      mem_insn_d    = mem_insn_q;
      if (redirect) begin
         fetch_pc_d = target_s;
         inflight_d = 1'b0;
         rd_ptr_d   = {PW{1'b0}};
         wr_ptr_d   = {PW{1'b0}};
         count_d    = {CW{1'b0}};
         fault_d    = misalign_s;
      end else begin
         // Every issued read returns the next cycle, so inflight tracks issue.
         inflight_d = issue_s;
         if (issue_s) begin
            inflight_pc_d = fetch_pc_q;
            fetch_pc_d    = fetch_pc_q + 32'd4;
         end else begin
            inflight_pc_d = inflight_pc_q;
         end
         if (push_s) begin
            mem_pc_d[wr_ptr_q]   = inflight_pc_q;
            mem_insn_d[wr_ptr_q] = imem_data;
            wr_ptr_d             = wr_ptr_q + PTR_ONE;
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         count_d = count_q + CW'(push_s) - CW'(pop_s);
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         fetch_pc_q    <= RESET_PC;
         inflight_q    <= 1'b0;
         inflight_pc_q <= 32'h0000_0000;
         rd_ptr_q      <= {PW{1'b0}};
         wr_ptr_q      <= {PW{1'b0}};
         count_q       <= {CW{1'b0}};
         fault_q       <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_pc_q[i]   <= 32'h0000_0000;
            mem_insn_q[i] <= 32'h0000_0000;
         end
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         inflight_q    <= inflight_d;
         inflight_pc_q <= inflight_pc_d;
         rd_ptr_q      <= rd_ptr_d;
         wr_ptr_q      <= wr_ptr_d;
         count_q       <= count_d;
         fault_q       <= fault_d;
         for (int i = 0; i < DEPTH; i++) begin
            mem_pc_q[i]   <= mem_pc_d[i];
            mem_insn_q[i] <= mem_insn_d[i];
         end
      end
   end

   // Outputs derived only from registered state (plus the issue decision).
   always_comb begin
      imem_req  = issue_s;
      imem_addr = fetch_pc_q;
      count     = count_q;
      fault     = fault_q;
      out_valid = (count_q != {CW{1'b0}});
      if (count_q != {CW{1'b0}}) begin
         out_pc   = mem_pc_q[rd_ptr_q];
         out_insn = mem_insn_q[rd_ptr_q];
      end else begin
         out_pc   = 32'h0000_0000;
         out_insn = 32'h0000_0000;
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue (DEPTH=4).
// The memory model returns the requested address as the instruction word.
module tb_fetch_queue;

   localparam logic [31:0] RPC = 32'h0100_0000;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_data = 32'h0000_0000;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = 32'h0000_0000;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] out_pc;
   logic [31:0] out_insn;
   logic [2:0]  count;
   logic        fault;

   int total = 0;
   int bad   = 0;
   int reqs  = 0;

   fetch_queue #(.DEPTH(4), .RESET_PC(RPC)) dut (
      .clock       (clock),
      .reset       (reset),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_data   (imem_data),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_pc      (out_pc),
      .out_insn    (out_insn),
      .count       (count),
      .fault       (fault)
   );

   always #5 clock = ~clock;

   // Memory responds one cycle after a request with data equal to the address.
   always @(posedge clock) begin
      if (imem_req) imem_data <= imem_addr;
      else          imem_data <= 32'hDEAD_BEEF;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%08h want=%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      @(negedge clock);
   endtask

   initial begin
      // Reset held low
      repeat (3) tick();
      chk("rst_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_count", {29'd0, count}, 32'd0);
      chk("rst_req",   {31'd0, imem_req}, 32'd0);
      chk("rst_fault", {31'd0, fault}, 32'd0);
      chk("rst_pc",    out_pc, 32'd0);

      // Release, stream with out_ready=1
      reset = 1'b1; #1;
      chk("c0_req",  {31'd0, imem_req}, 32'd1);
      chk("c0_addr", imem_addr, RPC);
      tick();
      chk("c1_valid", {31'd0, out_valid}, 32'd0);
      chk("c1_addr",  imem_addr, RPC + 32'd4);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("strm_valid", {31'd0, out_valid}, 32'd1);
         chk("strm_pc",    out_pc,   RPC + 32'(4 * k));
         chk("strm_insn",  out_insn, RPC + 32'(4 * k));
      end

      // Backpressure: exactly 4 requests then hold
      reset = 1'b0; out_ready = 1'b0; #1;
      tick();
      reset = 1'b1; #1;
      reqs = 0;
      for (int i = 0; i < 10; i++) begin
         if (imem_req) reqs++;
         tick();
      end
      chk("bp_reqs",  32'(reqs), 32'd4);
      chk("bp_count", {29'd0, count}, 32'd4);
      chk("bp_req",   {31'd0, imem_req}, 32'd0);
      out_ready = 1'b1; #1;
      for (int k = 0; k < 5; k++) begin
         chk("drain_valid", {31'd0, out_valid}, 32'd1);
         chk("drain_pc",    out_pc, RPC + 32'(4 * k));
         tick();
      end

      // Redirect with count=3 and a read in flight
      reset = 1'b0; out_ready = 1'b0; #1;
      tick();
      reset = 1'b1; #1;
      repeat (4) tick();
      chk("rd_pre_count", {29'd0, count}, 32'd3);
      redirect = 1'b1; redirect_pc = 32'h0100_0100; out_ready = 1'b1; #1;
      chk("rd_r_req", {31'd0, imem_req}, 32'd0);
      tick();
      redirect = 1'b0; #1;
      chk("rd_r1_count", {29'd0, count}, 32'd0);
      chk("rd_r1_req",   {31'd0, imem_req}, 32'd1);
      chk("rd_r1_addr",  imem_addr, 32'h0100_0100);
      chk("rd_r1_valid", {31'd0, out_valid}, 32'd0);
      tick();
      chk("rd_r2_valid", {31'd0, out_valid}, 32'd0);
      tick();
      chk("rd_r3_valid", {31'd0, out_valid}, 32'd1);
      chk("rd_r3_pc",    out_pc,   32'h0100_0100);
      chk("rd_r3_insn",  out_insn, 32'h0100_0100);
      tick();
      chk("rd_r4_pc", out_pc, 32'h0100_0104);

      // PC wrap at 2^32
      redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC; #1;
      tick();
      redirect = 1'b0; #1;
      chk("wr_addr", imem_addr, 32'hFFFF_FFFC);
      tick();
      tick();
      chk("wr_pc0", out_pc, 32'hFFFF_FFFC);
      tick();
      chk("wr_valid1", {31'd0, out_valid}, 32'd1);
      chk("wr_pc1",    out_pc,   32'h0000_0000);
      chk("wr_insn1",  out_insn, 32'h0000_0000);

      // Misaligned redirect
      redirect = 1'b1; redirect_pc = 32'h0100_0102; #1;
      tick();
      redirect = 1'b0; #1;
`ifdef FETCH_MISALIGN_CHECK_EN
      chk("ma_fault", {31'd0, fault}, 32'd1);
      chk("ma_req",   {31'd0, imem_req}, 32'd0);
      chk("ma_count", {29'd0, count}, 32'd0);
      tick();
      chk("ma_req2",   {31'd0, imem_req}, 32'd0);
      chk("ma_valid2", {31'd0, out_valid}, 32'd0);
      redirect = 1'b1; redirect_pc = 32'h0100_0200; #1;
      tick();
      redirect = 1'b0; #1;
      chk("ma_clr_fault", {31'd0, fault}, 32'd0);
      chk("ma_clr_req",   {31'd0, imem_req}, 32'd1);
      chk("ma_clr_addr",  imem_addr, 32'h0100_0200);
      tick();
      tick();
      chk("ma_res_pc", out_pc, 32'h0100_0200);
`else
      chk("ma_fault", {31'd0, fault}, 32'd0);
      chk("ma_addr",  imem_addr, 32'h0100_0100);
      tick();
      tick();
      chk("ma_pc",   out_pc,   32'h0100_0100);
      chk("ma_insn", out_insn, 32'h0100_0100);
`endif

      // Asynchronous reset mid-stream with count=2
      redirect = 1'b1; redirect_pc = 32'h0100_0300; out_ready = 1'b0; #1;
      tick();
      redirect = 1'b0; #1;
      tick();
      tick();
      chk("ar_count1", {29'd0, count}, 32'd1);
      tick();
      chk("ar_count2", {29'd0, count}, 32'd2);
      reset = 1'b0; #1;
      chk("ar_valid", {31'd0, out_valid}, 32'd0);
      chk("ar_count", {29'd0, count}, 32'd0);
      chk("ar_req",   {31'd0, imem_req}, 32'd0);
      chk("ar_pc",    out_pc, 32'd0);
      tick();
      reset = 1'b1; out_ready = 1'b1; #1;
      chk("ar_rel_req",  {31'd0, imem_req}, 32'd1);
      chk("ar_rel_addr", imem_addr, RPC);
      tick();
      tick();
      chk("ar_rel_pc", out_pc, RPC);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Decoupled instruction-fetch front end for the RV32 core. It owns the fetch PC, issues sequential reads to `imemory`, and buffers returned instructions with their PCs in a small FIFO. Decode consumes them over a valid/ready handshake. Execute redirects the stream on taken branches, JAL and JALR by flushing the queue and any in-flight read.

## Interface
Parameters:
- `DEPTH`, 4: queue entries; power of two, ≥2.
- `RESET_PC`, 32'h01000000: fetch PC after reset.

Ports:
- `clock`  in  1  sole clock; all state updates on posedge.
- `reset`  in  1  asynchronous, active-low; while low, all state is held at reset values.
- `imem_req`  out  1  read request to `imemory` this cycle.
- `imem_addr`  out  32  read address; equals `fetch_pc`.
- `imem_data`  in  32  read data, valid the cycle after a request.
- `redirect`  in  1  flush-and-redirect strobe from execute.
- `redirect_pc`  in  32  new fetch target; sampled when `redirect`=1.
- `out_valid`  out  1  head entry valid for decode.
- `out_ready`  in  1  decode accepts the head entry.
- `out_pc`  out  32  PC of the head entry.
- `out_insn`  out  32  instruction word of the head entry.
- `count`  out  $clog2(DEPTH+1)  number of occupied entries.
- `fault`  out  1  misaligned-redirect fault; see Configuration.

## Operation
- State:
  - `fetch_pc`
  - `inflight` flag plus `inflight_pc`
  - FIFO storage of {pc, insn} × DEPTH
  - `rd_ptr` / `wr_ptr`, each mod DEPTH
  - `count`
- Reset values:
  - `fetch_pc`=RESET_PC
  - `inflight`=0
  - pointers=0
  - `count`=0
  - `fault`=0
  - `out_valid`=0
  - `imem_req`=0
  - `out_pc`/`out_insn`=0
- Issue:
  - `imem_req` = `reset` & !`redirect` & !`fault` & (`count` + `inflight` < DEPTH).
  - The credit check uses pre-pop occupancy, which is conservative.
  - On issue: `inflight`<=1, `inflight_pc`<=`fetch_pc`, `fetch_pc`<=`fetch_pc`+4.
  - `fetch_pc` increments mod 2^32, so 0xFFFFFFFC wraps to 0x00000000.
- Fill:
  - When `inflight`=1 and there is no redirect, write {`inflight_pc`, `imem_data`} at `wr_ptr`.
  - Then `wr_ptr`++ and `inflight` is cleared unless a new issue occurs in the same cycle.
- Drain:
  - `out_valid` = (`count`≠0).
  - Head fields come from `rd_ptr`.
  - A pop occurs when `out_valid` & `out_ready`; it advances `rd_ptr`.
- Count update: push and pop in the same cycle leave `count` unchanged.
- Redirect has highest priority:
  - Next state: `count`=0, pointers=0, `inflight`=0, and `fetch_pc`<=`redirect_pc`.
  - The in-flight response returning that cycle is discarded.
  - A handshake in the redirect cycle still counts as consumed by decode; the queue is flushed regardless.
- Pointers wrap mod DEPTH; `count` never exceeds DEPTH by construction.
- Asynchronous reset mid-operation: all state returns to reset values immediately.
  - An outstanding memory response is ignored because `inflight`=0.

## Timing
- Issue→visible latency is 2 cycles:
  - request at cycle N;
  - data written at the end of N+1;
  - `out_valid` high in N+2.
- First cycle after reset deassertion: `imem_req`=1 with `imem_addr`=RESET_PC.
- Redirect at cycle R:
  - no request in R;
  - request to `redirect_pc` in R+1;
  - `out_valid` with `out_pc`=`redirect_pc` in R+3.
- Steady-state throughput is 1 instruction/cycle when `out_ready` is held high.
- Backpressure: with `out_ready`=0, the block issues exactly DEPTH requests, then holds `imem_req`=0 with `count`=DEPTH.
- Outputs `out_*` and `count` are pure functions of registered state; they have no combinational path from `out_ready` or `redirect`.

## Configuration
- `FETCH_MISALIGN_CHECK_EN` defined:
  - A redirect with `redirect_pc[1:0]`≠0 sets `fault`=1 the next cycle.
  - The queue is still flushed.
  - Issue stops while `fault`=1.
  - `fault` clears on the next redirect with an aligned target, which resumes fetching normally.
- Undefined:
  - `fault` is tied 0.
  - `redirect_pc[1:0]` are forced to 0 when loaded into `fetch_pc`.

## Test plan
- Reset release, `out_ready`=1, memory returns word=address → cycles 2,3,4 show `out_pc`=0x01000000/04/08 and `out_insn` equal to each PC.
- `out_ready`=0 for 10 cycles (DEPTH=4) → exactly 4 requests issued, `count`=4, `imem_req`=0.
  - Then raise `out_ready` → entries drain in PC order 0x01000000…0x0100000C with no gaps.
- Redirect to 0x01000100 while `count`=3 and a request is in flight → `count`=0 next cycle, stale data never appears, `out_pc`=0x01000100 three cycles after redirect.
- Redirect to 0xFFFFFFFC, `out_ready`=1 → consecutive `out_pc` values 0xFFFFFFFC then 0x00000000.
- With `FETCH_MISALIGN_CHECK_EN`: redirect to 0x01000102 → `fault`=1, `imem_req`=0, `count`=0.
  - Then redirect to 0x01000200 → `fault`=0, fetch resumes at 0x01000200.
- Assert `reset` low mid-stream with `count`=2 → immediately `out_valid`=0 and `count`=0.
  - After release, fetch restarts at RESET_PC.
